// File: rtl/vm_refund_dispenser.sv
// rtl/vm_refund_dispenser.sv - vend motor sequencer and two-hopper coin refund payout
module vm_refund_dispenser #(
  parameter int VEND_CYCLES = 50,
  parameter int ACK_TIMEOUT = 1000,
  parameter int HI_VALUE    = 2,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ship,
  input  logic       change,
  input  logic [2:0] refund,
  input  logic       coin_ack,
  output logic       coin_req,
  output logic       coin_sel,
  output logic       motor_on,
  output logic       busy,
  output logic       fault,
  output logic [7:0] sold_cnt,
  output logic [7:0] refund_cnt
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int VW = (VEND_CYCLES > 1) ? $clog2(VEND_CYCLES) : 1;
  localparam logic [2:0]    HI_V      = 3'(HI_VALUE);
  localparam logic [PW-1:0] PTR_LAST  = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMO_LAST  = TW'(ACK_TIMEOUT - 1);
  localparam logic [VW-1:0] VEND_LAST = VW'(VEND_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, REQ, GAP, FAULT} state_t;

  state_t          state, state_nxt;
  logic [2:0]      fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   fifo_cnt;
  logic [2:0]      remaining;
  logic [TW-1:0]   req_timer;
  logic [VW-1:0]   vend_timer;
  logic [1:0]      pending;

  logic fifo_empty, fifo_full, refund_valid, push, pop, overflow;
  logic sel_hi, ack_hit, timeout, vend_done, ship_ovf;
  logic [2:0] coin_val, rem_after;
  logic [8:0] cnt_sum;

  assign fifo_empty   = (fifo_cnt == '0);
  assign fifo_full    = (fifo_cnt == CNT_FULL);
  assign refund_valid = change && (refund != 3'd0) && (state != FAULT);
  assign push         = refund_valid && !fifo_full;
  assign overflow     = refund_valid && fifo_full;
  assign pop          = (state == LOAD) && !fifo_empty;

  assign sel_hi    = (remaining >= HI_V);
  assign coin_val  = sel_hi ? HI_V : 3'd1;
  assign rem_after = remaining - coin_val;
  assign ack_hit   = (state == REQ) && coin_ack;
  assign timeout   = (state == REQ) && !coin_ack && (req_timer == TMO_LAST);
  assign cnt_sum   = {1'b0, refund_cnt} + {6'd0, coin_val};

  assign vend_done = motor_on && (vend_timer == VEND_LAST);
  assign ship_ovf  = ship && motor_on && !vend_done && (pending == 2'd3);

  // Pending refunds; a timeout fault flushes everything still queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (state == FAULT) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
      if (push && !pop)      fifo_cnt <= fifo_cnt + CW'(1);
      else if (pop && !push) fifo_cnt <= fifo_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= refund;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // IDLE also reacts to an incoming push so the first coin request lands two cycles after change.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (!fifo_empty || push) state_nxt = LOAD;
      LOAD:  state_nxt = REQ;
      REQ: begin
        if (coin_ack) begin
          if (rem_after != 3'd0) state_nxt = GAP;
          else if (!fifo_empty)  state_nxt = LOAD;
          else                   state_nxt = IDLE;
        end else if (timeout) begin
          state_nxt = FAULT;
        end
      end
      GAP:   state_nxt = REQ;
      FAULT: state_nxt = FAULT;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    coin_req = (state == REQ);
    coin_sel = (state == REQ) && sel_hi;
    busy     = (state != IDLE) || !fifo_empty || motor_on;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining  <= '0;
      req_timer  <= '0;
      refund_cnt <= '0;
      fault      <= 1'b0;
    end else begin
      req_timer <= (state == REQ) ? req_timer + TW'(1) : '0;
      if (state == LOAD && !fifo_empty) remaining <= fifo_mem[rd_ptr];
      else if (ack_hit)                 remaining <= rem_after;
      else if (state == FAULT)          remaining <= '0;
      if (ack_hit) refund_cnt <= cnt_sum[8] ? 8'hff : cnt_sum[7:0];
      if (overflow || ship_ovf || timeout) fault <= 1'b1;
    end
  end

  // A ship landing on the completion cycle starts the next run directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      motor_on   <= 1'b0;
      vend_timer <= '0;
      pending    <= '0;
      sold_cnt   <= '0;
    end else if (!motor_on) begin
      vend_timer <= '0;
      if (ship) motor_on <= 1'b1;
    end else if (vend_done) begin
      sold_cnt   <= sold_cnt + 8'd1;
      vend_timer <= '0;
      if (pending != 2'd0) begin
        if (!ship) pending <= pending - 2'd1;
      end else begin
        motor_on <= ship;
      end
    end else begin
      vend_timer <= vend_timer + VW'(1);
      if (ship && pending != 2'd3) pending <= pending + 2'd1;
    end
  end

endmodule

// File: tb/tb_vm_refund_dispenser.sv
// tb/tb_vm_refund_dispenser.sv - directed self-checking bench for vm_refund_dispenser
module tb_vm_refund_dispenser;

  localparam int VC = 5;
  localparam int AT = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ship, change, coin_ack;
  logic [2:0] refund;
  logic       coin_req, coin_sel, motor_on, busy, fault;
  logic [7:0] sold_cnt, refund_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vm_refund_dispenser #(
    .VEND_CYCLES(VC),
    .ACK_TIMEOUT(AT),
    .HI_VALUE(2),
    .FIFO_DEPTH(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ship(ship),
    .change(change),
    .refund(refund),
    .coin_ack(coin_ack),
    .coin_req(coin_req),
    .coin_sel(coin_sel),
    .motor_on(motor_on),
    .busy(busy),
    .fault(fault),
    .sold_cnt(sold_cnt),
    .refund_cnt(refund_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic do_change(input logic [2:0] amt);
    change = 1'b1;
    refund = amt;
    tick();
    change = 1'b0;
    refund = 3'd0;
  endtask

  task automatic pay_coin(input string tag, input logic exp_sel);
    int w;
    w = 0;
    while (!coin_req && w < 50) begin
      tick();
      w++;
    end
    chk({tag, "_req"}, 32'(coin_req), 32'd1);
    chk({tag, "_sel"}, 32'(coin_sel), 32'(exp_sel));
    tick();
    tick();
    coin_ack = 1'b1;
    tick();
    coin_ack = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int gaps;
    logic ended;

    rst_n = 1'b0; ship = 1'b0; change = 1'b0; refund = 3'd0; coin_ack = 1'b0;
    tick();
    chk("rst_coin_req", 32'(coin_req), 32'd0);
    chk("rst_coin_sel", 32'(coin_sel), 32'd0);
    chk("rst_motor_on", 32'(motor_on), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_sold_cnt", 32'(sold_cnt), 32'd0);
    chk("rst_refund_cnt", 32'(refund_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // T1: 7 units -> HI,HI,HI,LO
    do_change(3'd7);
    chk("t1_lat_t1", 32'(coin_req), 32'd0);
    tick();
    chk("t1_lat_t2", 32'(coin_req), 32'd1);
    pay_coin("t1_c0", 1'b1);
    pay_coin("t1_c1", 1'b1);
    pay_coin("t1_c2", 1'b1);
    pay_coin("t1_c3", 1'b0);
    tick();
    tick();
    chk("t1_refund_cnt", 32'(refund_cnt), 32'd7);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_req_idle", 32'(coin_req), 32'd0);

    // T2: single LO coin, then a zero refund is ignored
    do_change(3'd1);
    pay_coin("t2_c0", 1'b0);
    tick();
    tick();
    chk("t2_refund_cnt", 32'(refund_cnt), 32'd8);
    do_change(3'd0);
    chk("t2_zero_busy_now", 32'(busy), 32'd0);
    tick();
    tick();
    chk("t2_zero_req", 32'(coin_req), 32'd0);
    chk("t2_zero_busy", 32'(busy), 32'd0);

    // T3: head is popped at once, so the fourth back-to-back refund finds the queue full
    do_change(3'd3);
    do_change(3'd2);
    do_change(3'd5);
    chk("t3_no_fault_yet", 32'(fault), 32'd0);
    do_change(3'd4);
    chk("t3_overflow_fault", 32'(fault), 32'd1);
    pay_coin("t3_a0", 1'b1);
    pay_coin("t3_a1", 1'b0);
    pay_coin("t3_b0", 1'b1);
    pay_coin("t3_c0", 1'b1);
    pay_coin("t3_c1", 1'b1);
    pay_coin("t3_c2", 1'b0);
    tick();
    tick();
    chk("t3_refund_cnt", 32'(refund_cnt), 32'd18);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_fault_sticky", 32'(fault), 32'd1);

    apply_reset();
    chk("rst2_fault", 32'(fault), 32'd0);
    chk("rst2_refund_cnt", 32'(refund_cnt), 32'd0);

    // T4: withheld ack -> timeout fault
    do_change(3'd3);
    tick();
    n = 0;
    while (coin_req && n < 100) begin
      n++;
      tick();
    end
    chk("t4_req_cycles", 32'(n), 32'(AT));
    chk("t4_fault", 32'(fault), 32'd1);
    do_change(3'd2);
    coin_ack = 1'b1;
    tick();
    coin_ack = 1'b0;
    tick();
    tick();
    chk("t4_ignored_req", 32'(coin_req), 32'd0);
    chk("t4_fault_busy", 32'(busy), 32'd1);
    chk("t4_refund_cnt", 32'(refund_cnt), 32'd0);

    apply_reset();

    // T5: single vend, then two ships merged into one continuous run
    ship = 1'b1;
    tick();
    ship = 1'b0;
    n = 0;
    while (motor_on && n < 100) begin
      n++;
      tick();
    end
    chk("t5_single_len", 32'(n), 32'(VC));
    chk("t5_single_sold", 32'(sold_cnt), 32'd1);

    ship = 1'b1;
    tick();
    ship = 1'b0;
    n = 0;
    gaps = 0;
    ended = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (motor_on) begin
        n++;
        if (ended) gaps++;
      end else begin
        ended = 1'b1;
      end
      ship = (i == 2);
      tick();
    end
    ship = 1'b0;
    chk("t5_double_len", 32'(n), 32'(2 * VC));
    chk("t5_double_gaps", 32'(gaps), 32'd0);
    chk("t5_double_sold", 32'(sold_cnt), 32'd3);

    // T6: asynchronous reset while paying out and vending
    change = 1'b1;
    refund = 3'd5;
    ship = 1'b1;
    tick();
    change = 1'b0;
    refund = 3'd0;
    ship = 1'b0;
    tick();
    chk("t6_pre_req", 32'(coin_req), 32'd1);
    chk("t6_pre_motor", 32'(motor_on), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_req", 32'(coin_req), 32'd0);
    chk("t6_async_sel", 32'(coin_sel), 32'd0);
    chk("t6_async_motor", 32'(motor_on), 32'd0);
    chk("t6_async_busy", 32'(busy), 32'd0);
    chk("t6_async_sold", 32'(sold_cnt), 32'd0);
    chk("t6_async_refund", 32'(refund_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("t6_refund_lost", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
